vedic_4x4_seq_ctrl: RTL
=======================

# vedic_4x4_seq_ctrl

Sequential 4x4 unsigned multiplier controller that time-shares a single combinational `vedic_2_x_2_mul` instance across four partial-product steps. It latches operands on a start request, steps through the operand halves, shifts and accumulates each partial product, and presents the 8-bit product with a one-cycle done pulse. It sits between a requesting datapath and the 2x2 Vedic multiplier core, trading latency for area.

## Interface
- No parameters; operand width fixed at 4, core width fixed at 2.
- Reset is asynchronous and active-low (`rst_n`); single clock domain (`clk`).
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous active-low reset.
- `start` input 1 — request; sampled on rising edge when state is IDLE or DONE.
- `a` input 4 — multiplicand, unsigned; sampled only with an accepted `start`.
- `b` input 4 — multiplier, unsigned; sampled only with an accepted `start`.
- `busy` output 1 — high while in MUL.
- `done` output 1 — high for exactly one cycle in DONE.
- `p` output 8 — product; valid while `done`=1 and held until the next accepted `start`.

## Operation
- States:
  - IDLE: reset state.
  - MUL: 2-bit step counter `step`.
  - DONE: one cycle.
- IDLE or DONE with `start`=1 at an edge:
  - latch `a_r`<=`a`, `b_r`<=`b`, `acc`<=0, `step`<=0.
  - go to MUL.
- DONE with `start`=0: go to IDLE.
- IDLE with `start`=0: stay.
- MUL steps (core inputs driven combinationally from `a_r`/`b_r` halves):
  - step 0: `a_r[1:0]`*`b_r[1:0]`, shift 0.
  - step 1: `a_r[3:2]`*`b_r[1:0]`, shift 2.
  - step 2: `a_r[1:0]`*`b_r[3:2]`, shift 2.
  - step 3: `a_r[3:2]`*`b_r[3:2]`, shift 4.
- Each MUL edge:
  - `acc`<=`acc`+({4'b0,c}<<shift), `step`<=`step`+1.
  - At step 3, also `p`<=`acc`+({4'b0,c}<<4) and go to DONE.
- Arithmetic:
  - Core output `c` is 4 bits, max 9.
  - Zero-extend to 8 bits before shifting.
  - Max result 225 fits 8 bits; no overflow handling.
- `start` while in MUL is ignored, with no queuing; the operation in flight is unaffected.
- `a`/`b` changes while in MUL have no effect.
- Reset (asynchronous, any state, including mid-MUL):
  - state=IDLE, `step`=0, `acc`=0, `a_r`=`b_r`=0.
  - `p`=0, `busy`=0, `done`=0.
  - The partial result is discarded.

## Timing
- All outputs are registered or decoded from state; no combinational path from `start`/`a`/`b` to outputs.
- Reset values:
  - `busy`=0, `done`=0, `p`=8'h00.
- Accepted `start` at edge E0:
  - `busy`=1 during cycles E0..E4.
  - Accumulation happens at E1..E4.
  - `p` updates and `done`=1 during cycle E4..E5; `busy`=0 in that cycle.
- Latency is 5 edges from start acceptance to `done`.
- Throughput is one product per 5 cycles when `start` is held or re-asserted in DONE:
  - back-to-back start is accepted at the same edge that leaves DONE.
  - `done` never lasts more than one cycle.
- `p` holds its value after DONE until the next accepted `start` edge E0, and does not change at E0; it changes only at E4 of the new operation.

## Structure
- Shared header/package `vedic_pkg`:
  - state encodings IDLE=2'd0, MUL=2'd1, DONE=2'd2.
  - step constants and shift amounts (0, 2, 2, 4).
  - operand width 4 and product width 8.
- One sub-module: the existing `vedic_2_x_2_mul` (ports `a`, `b`, `c`), instantiated once as `u_core`; operand-half mux and shifter are inline.
- Estimated 150–250 lines of RTL.

## Test plan
- `a`=15, `b`=15, start one cycle → `busy`=1 for 4 cycles, then `done`=1 for 1 cycle with `p`=225; `p` held at 225 afterwards.
- `a`=2, `b`=3 at edge E0 → `done` exactly in cycle E4–E5, `p`=6; `a`=0, `b`=9 also gives `p`=0 and `done` pulses.
- `a`=7, `b`=5 started, then `start` pulsed with `a`=1, `b`=1 at E2 → ignored; `p`=35 at E4; no second `done`.
- `start` held high continuously with `a`=3, `b`=4 → `done` every 5th cycle, `p`=12 each time, `done` single-cycle.
- `a`=9, `b`=6 started, `rst_n` low asynchronously at E2+half cycle → immediately `busy`=0, `done`=0, `p`=0; after release, a new start with `a`=9, `b`=6 gives `p`=54.
- Exhaustive sweep, all 256 (`a`,`b`) pairs → `p`=`a`*`b` for every pair, checked at `done`.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared constants for the sequential 4x4 Vedic multiplier: state encodings,
// step indices, per-step shift amounts and operand/product widths.
package vedic_pkg;

    localparam int OPER_W = 4;
    localparam int PROD_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] STEP_0 = 2'd0;
    localparam logic [1:0] STEP_1 = 2'd1;
    localparam logic [1:0] STEP_2 = 2'd2;
    localparam logic [1:0] STEP_3 = 2'd3;

    localparam logic [2:0] SHIFT_0 = 3'd0;
    localparam logic [2:0] SHIFT_1 = 3'd2;
    localparam logic [2:0] SHIFT_2 = 3'd2;
    localparam logic [2:0] SHIFT_3 = 3'd4;

    // Weight of each partial product: cross terms land at bit 2, high*high at bit 4.
    function automatic logic [2:0] step_shift(input logic [1:0] step);
        case (step)
            STEP_0:  step_shift = SHIFT_0;
            STEP_1:  step_shift = SHIFT_1;
            STEP_2:  step_shift = SHIFT_2;
            default: step_shift = SHIFT_3;
        endcase
    endfunction

endpackage

// File: rtl/vedic_2_x_2_mul.sv
// Combinational 2x2 unsigned Vedic multiplier core (vertical and crosswise).
module vedic_2_x_2_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] c
);

    logic cross_lo;
    logic cross_hi;
    logic carry;
    logic high;

    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign carry    = cross_lo & cross_hi;
    assign high     = a[1] & b[1];

    assign c[0] = a[0] & b[0];
    assign c[1] = cross_lo ^ cross_hi;
    assign c[2] = high ^ carry;
    assign c[3] = high & carry;

endmodule

// File: rtl/vedic_4x4_seq_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shared 2x2 Vedic core is stepped over
// the four operand-half pairs and the shifted partial products are accumulated.
module vedic_4x4_seq_ctrl
    import vedic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OPER_W-1:0] a,
    input  logic [OPER_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    logic [1:0]        state;
    logic [1:0]        step;
    logic [PROD_W-1:0] acc;
    logic [OPER_W-1:0] a_r;
    logic [OPER_W-1:0] b_r;

    logic [1:0]        core_a;
    logic [1:0]        core_b;
    logic [3:0]        core_c;
    logic [PROD_W-1:0] partial;
    logic [PROD_W-1:0] acc_nxt;

    // step[0] picks the high half of a, step[1] the high half of b.
    always_comb begin
        core_a  = step[0] ? a_r[3:2] : a_r[1:0];
        core_b  = step[1] ? b_r[3:2] : b_r[1:0];
        partial = {4'b0, core_c} << step_shift(step);
        acc_nxt = acc + partial;
    end

    vedic_2_x_2_mul u_core (
        .a (core_a),
        .b (core_b),
        .c (core_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= STEP_0;
            acc   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            p     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        step  <= STEP_0;
                        state <= ST_MUL;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc  <= acc_nxt;
                    step <= step + 2'd1;
                    if (step == STEP_3) begin
                        p     <= acc_nxt;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_MUL);
    assign done = (state == ST_DONE);

endmodule
